// File: rtl/nios_ii_system_cpu_mulx_pkg.sv
// rtl/nios_ii_system_cpu_mulx_pkg.sv - shared op codes, FSM states and latencies for the multiply sequencer
package nios_ii_system_cpu_mulx_pkg;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXUU = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXSS = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIX   = 2'd3
    } state_t;

    localparam int LAT_FULL = 6;
    localparam int LAT_FAST = 4;

endpackage

// File: rtl/nios_ii_system_cpu_mulx_pp.sv
// rtl/nios_ii_system_cpu_mulx_pp.sv - shared H x H unsigned multiplier with one output register
module nios_ii_system_cpu_mulx_pp #(
    parameter int H = 16
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    output logic [2*H-1:0] p
);

    // Registered unsigned product; zero-extended operands keep the full 2H-bit result.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            p <= '0;
        end else begin
            p <= {{H{1'b0}}, a} * {{H{1'b0}}, b};
        end
    end

endmodule

// File: rtl/nios_ii_system_cpu_mulx_seq.sv
// rtl/nios_ii_system_cpu_mulx_seq.sv - 4-pass 32x32->64 multiply sequencer (MUL/MULXUU/MULXSU/MULXSS), optional MULX_FAST_MUL_EN
module nios_ii_system_cpu_mulx_seq
    import nios_ii_system_cpu_mulx_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int H = WIDTH / 2;

`ifdef MULX_FAST_MUL_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    state_t               state;
    state_t               state_next;
    logic [1:0]           cnt;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   corr_a;
    logic [2*WIDTH-1:0]   corr_b;
    logic [2*WIDTH-1:0]   acc_fix;
    logic [1:0]           pp_idx;
    logic [H-1:0]         mul_a;
    logic [H-1:0]         mul_b;
    logic [WIDTH-1:0]     pp_q;
    logic                 pp_clr;
    logic                 fast_op;
    logic                 last_run;

    assign busy     = (state != IDLE);
    assign fast_op  = FAST_EN && (op_q == OP_MUL);
    assign last_run = (state == RUN) && (cnt == 2'd3);
    assign pp_clr   = ~reset_n;

    nios_ii_system_cpu_mulx_pp #(
        .H (H)
    ) u_pp (
        .clk (clk),
        .clr (pp_clr),
        .a   (mul_a),
        .b   (mul_b),
        .p   (pp_q)
    );

    // Pick this cycle's partial-product operands; the fast MUL path leaves k3 idle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == RUN && !(fast_op && cnt == 2'd3)) begin
            case (cnt)
                2'd0: begin mul_a = a_q[H-1:0];     mul_b = b_q[H-1:0];     end
                2'd1: begin mul_a = a_q[WIDTH-1:H]; mul_b = b_q[H-1:0];     end
                2'd2: begin mul_a = a_q[H-1:0];     mul_b = b_q[WIDTH-1:H]; end
                default: begin mul_a = a_q[WIDTH-1:H]; mul_b = b_q[WIDTH-1:H]; end
            endcase
        end
    end

    // The product on the multiplier output lags the issued index by one cycle; DRAIN sees k3.
    always_comb begin
        pp_idx = (state == DRAIN) ? 2'd3 : (cnt - 2'd1);
        addend = '0;
        case (pp_idx)
            2'd0:    addend = {{WIDTH{1'b0}}, pp_q};
            2'd1,
            2'd2:    addend = {{H{1'b0}}, pp_q, {H{1'b0}}};
            default: addend = {pp_q, {WIDTH{1'b0}}};
        endcase
        acc_sum = acc + addend;
    end

    // Signed correction: the unsigned product over-counts 2^W times the other operand per negative input.
    always_comb begin
        corr_b = '0;
        corr_a = '0;
        if ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[WIDTH-1]) begin
            corr_b = {b_q, {WIDTH{1'b0}}};
        end
        if (op_q == OP_MULXSS && b_q[WIDTH-1]) begin
            corr_a = {a_q, {WIDTH{1'b0}}};
        end
        acc_fix = acc - corr_b - corr_a;
    end

    // Next-state logic: RUN issues four products, then DRAIN and FIX unless fast MUL finishes early.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 2'd3) state_next = fast_op ? IDLE : DRAIN;
            DRAIN:   state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, accumulation, correction and the one-cycle done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= src1;
                        b_q  <= src2;
                        op_q <= op;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 2'd1;
                    if (cnt != 2'd0) begin
                        acc <= acc_sum;
                    end
                    if (last_run && fast_op) begin
                        result <= acc_sum[WIDTH-1:0];
                        done   <= 1'b1;
                    end
                end
                DRAIN: begin
                    acc <= acc_sum;
                end
                FIX: begin
                    acc    <= acc_fix;
                    result <= (op_q == OP_MUL) ? acc_fix[WIDTH-1:0] : acc_fix[2*WIDTH-1:WIDTH];
                    done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_ii_system_cpu_mulx_seq.sv
// tb/tb_nios_ii_system_cpu_mulx_seq.sv - directed and random self-checking bench for the multiply sequencer
module tb_nios_ii_system_cpu_mulx_seq;
    import nios_ii_system_cpu_mulx_pkg::*;

`ifdef MULX_FAST_MUL_EN
    localparam int MUL_LAT = LAT_FAST;
`else
    localparam int MUL_LAT = LAT_FULL;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_err    = 0;

    nios_ii_system_cpu_mulx_seq #(
        .WIDTH (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .src1    (src1),
        .src2    (src2),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = {32'h0, a};
        eb = {32'h0, b};
        if (o == OP_MULXSU || o == OP_MULXSS) ea = {{32{a[31]}}, a};
        if (o == OP_MULXSS) eb = {{32{b[31]}}, b};
        p = ea * eb;
        return (o == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    // Issue one op; returns result, cycles from accept to done, and busy-high cycles.
    // With poke set, a conflicting start is pulsed mid-operation.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke,
                         output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk); #1;
        start = 1'b0; src1 = ~a; src2 = b ^ 32'h5A5A_A5A5;
        lat = -1; res = '0; bcnt = busy ? 1 : 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = cyc;
                res = result;
                break;
            end
            if (busy) bcnt++;
            if (poke && cyc == 2) begin
                start = 1'b1; op = OP_MULXSS; src1 = 32'h8000_0001; src2 = 32'h7FFF_FFFF;
            end
        end
    endtask

    logic [31:0] res;
    int          lat;
    int          bcnt;
    int          dcnt;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'd0; src1 = '0; src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_result", result, 0);
        @(negedge clk) reset_n = 1'b1;

        do_op(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, bcnt);
        check_eq("uu_max_res", res, 32'hFFFF_FFFE);
        check_eq("uu_max_lat", lat, LAT_FULL);
        check_eq("uu_max_busy", bcnt, 6);

        do_op(OP_MUL, 32'h0001_0003, 32'h0002_0005, 0, res, lat, bcnt);
        check_eq("mul_res", res, 32'h000B_000F);
        check_eq("mul_lat", lat, MUL_LAT);

        do_op(OP_MULXUU, 32'h0001_0003, 32'h0002_0005, 0, res, lat, bcnt);
        check_eq("uu_small_res", res, 32'h0000_0002);

        do_op(OP_MULXSS, 32'hFFFF_FFFF, 32'h0000_0002, 0, res, lat, bcnt);
        check_eq("ss_m1x2_res", res, 32'hFFFF_FFFF);
        check_eq("ss_m1x2_lat", lat, LAT_FULL);

        do_op(OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, bcnt);
        check_eq("ss_m1xm1_res", res, 32'h0000_0000);

        do_op(OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, bcnt);
        check_eq("su_m1xmax_res", res, 32'hFFFF_FFFF);

        do_op(OP_MULXUU, 32'h0001_0003, 32'h0002_0005, 1, res, lat, bcnt);
        check_eq("poke_res", res, 32'h0000_0002);
        check_eq("poke_lat", lat, LAT_FULL);
        @(posedge clk); #1;
        check_eq("poke_not_queued", busy, 0);

        do_op(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, bcnt);
        check_eq("b2b_first_res", res, 32'hFFFF_FFFE);
        start = 1'b1; op = OP_MULXSS; src1 = 32'hFFFF_FFFF; src2 = 32'h0000_0002;
        lat = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = cyc;
                res = result;
                break;
            end
        end
        check_eq("b2b_gap", lat, 7);
        check_eq("b2b_second_res", res, 32'hFFFF_FFFF);

        @(negedge clk);
        start = 1'b1; op = OP_MULXUU; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_result", result, 0);
        @(negedge clk) reset_n = 1'b1;
        dcnt = 0;
        @(posedge clk); #1;
        check_eq("midrst_idle_after", busy, 0);
        for (int i = 0; i < 10; i++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        check_eq("midrst_no_done", dcnt, 0);
        do_op(OP_MUL, 32'h0001_0003, 32'h0002_0005, 0, res, lat, bcnt);
        check_eq("midrst_next_res", res, 32'h000B_000F);

        for (int i = 0; i < 2000; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) ra = {1'b1, ra[30:0]};
            if (i % 8 == 1) rb = {1'b1, rb[30:0]};
            do_op(ro, ra, rb, 0, res, lat, bcnt);
            check_eq("rand_res", res, ref_model(ro, ra, rb));
            check_eq("rand_lat", lat, (ro == OP_MUL) ? MUL_LAT : LAT_FULL);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
